fifo_sdram_arbiter: RTL and testbench

FIFO_SDRAM_ARBITER -- requirements
Module: fifo_sdram_arbiter

---
 rtl/fifo_sdram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fifo_sdram_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sdram_arbiter.sv
// Round-robin arbiter that pops requests from N_CH FIFOs, issues one SDRAM command at a time,
// and returns read data to the matching response FIFO.
module fifo_sdram_arbiter #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8,
  parameter int RD_W   = 16,
  parameter int HOLD   = 1,
  parameter int RD_LAT = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sdram_ready,
  input  logic [N_CH-1:0]                     req_empty,
  output logic [N_CH-1:0]                     req_rd,
  input  logic [N_CH*(ADDR_W+DATA_W+2)-1:0]   req_data,
  input  logic [N_CH-1:0]                     rsp_full,
  output logic [N_CH-1:0]                     rsp_wr,
  output logic [RD_W-1:0]                     rsp_data,
  output logic [ADDR_W-1:0]                   sd_addr,
  output logic [DATA_W-1:0]                   sd_din,
  output logic                                sd_aux,
  output logic                                sd_we,
  input  logic [RD_W-1:0]                     sd_dout,
  output logic                                err,
  input  logic                                err_clr
);

  localparam int REQ_W = ADDR_W + DATA_W + 2;
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_CMD, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               aux_q, aux_d;
  logic [N_CH-1:0]    rsp_wr_q, rsp_wr_d;
  logic [RD_W-1:0]    rsp_data_q, rsp_data_d;
  logic               err_q, err_d;

  logic [N_CH-1:0]    elig;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic               can_grant;
  logic [REQ_W-1:0]   slice;
  logic               err_set;

  assign elig = ~req_empty & ~rsp_full;

  // first eligible channel at or after ptr, wrapping
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr_q) + i) % N_CH;
      if (!grant_vld && elig[PTR_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  // rst gates the strobe so no FIFO is popped while the block is held in reset
  assign can_grant = rst && sdram_ready && grant_vld && (state_q == S_IDLE);
  assign slice     = req_data[int'(ch_q)*REQ_W +: REQ_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (can_grant) state_d = S_POP;
      S_POP:  state_d = S_CMD;
      S_CMD:  if (cnt_q == '0) state_d = wr_q ? S_IDLE : S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_rd = '0;
    if (can_grant) req_rd[grant_idx] = 1'b1;
    sd_we = (state_q == S_CMD) && wr_q;
  end

  always_comb begin
    int nxt;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    aux_d      = aux_q;
    rsp_wr_d   = '0;
    rsp_data_d = rsp_data_q;
    err_set    = 1'b0;
    nxt        = int'(grant_idx) + 1;
    if (nxt >= N_CH) nxt = 0;
    if (can_grant) begin
      ptr_d = PTR_W'(nxt);
      ch_d  = grant_idx;
    end
    case (state_q)
      S_POP: begin
        addr_d = slice[REQ_W-1 -: ADDR_W];
        din_d  = slice[2 +: DATA_W];
        aux_d  = slice[1];
        wr_d   = slice[0];
        cnt_d  = CNT_W'(HOLD - 1);
        if (req_empty[ch_q]) err_set = 1'b1;
      end
      S_CMD: begin
        if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
        else if (!wr_q)   cnt_d = CNT_W'(RD_LAT - HOLD);
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rsp_full[ch_q]) begin
          err_set = 1'b1;
        end else begin
          rsp_wr_d[ch_q] = 1'b1;
          rsp_data_d     = sd_dout;
        end
      end
      default: ;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      aux_q      <= 1'b0;
      rsp_wr_q   <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      aux_q      <= aux_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign sd_addr  = addr_q;
  assign sd_din   = din_q;
  assign sd_aux   = aux_q;
  assign rsp_wr   = rsp_wr_q;
  assign rsp_data = rsp_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fifo_sdram_arbiter.sv
// Scoreboard bench for fifo_sdram_arbiter: expected commands/responses are queued at grant time
// and consumed by a monitor when the DUT drives sd_we or rsp_wr.
module tb_fifo_sdram_arbiter;
  localparam int N_CH = 2, ADDR_W = 21, DATA_W = 8, RD_W = 16, HOLD = 1, RD_LAT = 2;
  localparam int REQ_W = ADDR_W + DATA_W + 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    sdram_ready;
  logic [N_CH-1:0]         req_empty;
  logic [N_CH-1:0]         req_rd;
  logic [N_CH*REQ_W-1:0]   req_data;
  logic [N_CH-1:0]         rsp_full;
  logic [N_CH-1:0]         rsp_wr;
  logic [RD_W-1:0]         rsp_data;
  logic [ADDR_W-1:0]       sd_addr;
  logic [DATA_W-1:0]       sd_din;
  logic                    sd_aux;
  logic                    sd_we;
  logic [RD_W-1:0]         sd_dout;
  logic                    err;
  logic                    err_clr;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] din; logic aux;} wr_t;
  typedef struct {int ch; logic [RD_W-1:0] data;} rsp_t;
  wr_t  wr_q[$];
  rsp_t rsp_q[$];

  fifo_sdram_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_W(RD_W), .HOLD(HOLD), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .sdram_ready(sdram_ready),
    .req_empty(req_empty), .req_rd(req_rd), .req_data(req_data),
    .rsp_full(rsp_full), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_aux(sd_aux), .sd_we(sd_we),
    .sd_dout(sd_dout), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] pack(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                            input logic aux, input logic w);
    return {a, d, aux, w};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  // monitor: sample 3 time units after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        check("rd_onehot", 64'($countones(req_rd) <= 1), 64'd1);
        check("wr_onehot", 64'($countones(rsp_wr) <= 1), 64'd1);
        if (sd_we) begin
          if (wr_q.size() == 0) check("we_unexpected", 64'(sd_we), 64'd0);
          else begin
            wr_t e;
            e = wr_q.pop_front();
            check("sb_addr", 64'(sd_addr), 64'(e.addr));
            check("sb_din", 64'(sd_din), 64'(e.din));
            check("sb_aux", 64'(sd_aux), 64'(e.aux));
          end
        end
        if (rsp_wr != '0) begin
          if (rsp_q.size() == 0) check("rsp_unexpected", 64'(rsp_wr), 64'd0);
          else begin
            rsp_t r;
            logic [N_CH-1:0] ew;
            r = rsp_q.pop_front();
            ew = '0;
            ew[r.ch] = 1'b1;
            check("sb_rsp_ch", 64'(rsp_wr), 64'(ew));
            check("sb_rsp_data", 64'(rsp_data), 64'(r.data));
          end
        end
      end
    end
  end

  initial begin
    logic [N_CH-1:0] exp_rd;
    rst = 1'b0; sdram_ready = 1'b0; req_empty = '1; rsp_full = '0; err_clr = 1'b0;
    req_data = '0; sd_dout = 16'h0F0F;
    repeat (3) nxt();
    // in reset with traffic pending: nothing may be granted
    sdram_ready = 1'b1; req_empty = '0;
    smp();
    check("rst_req_rd", 64'(req_rd), 64'd0);
    check("rst_rsp_wr", 64'(rsp_wr), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_sd_addr", 64'(sd_addr), 64'd0);
    check("rst_sd_din", 64'(sd_din), 64'd0);
    check("rst_sd_aux", 64'(sd_aux), 64'd0);
    check("rst_sd_we", 64'(sd_we), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    nxt(); req_empty = '1; rst = 1'b1;

    // single write on ch0
    nxt();
    req_data[0 +: REQ_W] = pack(21'h00123, 8'hA5, 1'b0, 1'b1);
    req_empty[0] = 1'b0;
    wr_q.push_back('{21'h00123, 8'hA5, 1'b0});
    smp(); check("w_grant", 64'(req_rd), 64'd1);
    nxt(); smp(); check("w_pop_rd", 64'(req_rd), 64'd0); check("w_pop_we", 64'(sd_we), 64'd0);
    nxt(); req_empty[0] = 1'b1;
    smp(); check("w_cmd_we", 64'(sd_we), 64'd1);
    check("w_cmd_addr", 64'(sd_addr), 64'h00123); check("w_cmd_din", 64'(sd_din), 64'hA5);
    nxt(); smp(); check("w_done_we", 64'(sd_we), 64'd0);

    // read on ch1, sdram_ready dropping mid-transaction
    req_data[REQ_W +: REQ_W] = pack(21'h1F000, 8'h00, 1'b1, 1'b0);
    req_empty[1] = 1'b0;
    rsp_q.push_back('{1, 16'hBEEF});
    smp(); check("r_grant", 64'(req_rd), 64'd2);
    nxt(); sdram_ready = 1'b0;
    nxt(); req_empty[1] = 1'b1;
    smp(); check("r_addr", 64'(sd_addr), 64'h1F000); check("r_aux", 64'(sd_aux), 64'd1);
    check("r_we", 64'(sd_we), 64'd0);
    nxt();
    nxt(); sd_dout = 16'hBEEF;
    nxt(); sd_dout = 16'h0F0F; sdram_ready = 1'b1;
    smp(); check("r_rsp_wr", 64'(rsp_wr), 64'd2); check("r_rsp_data", 64'(rsp_data), 64'hBEEF);
    nxt(); smp(); check("r_rsp_end", 64'(rsp_wr), 64'd0);

    // both channels full of writes: grants alternate 0,1,0,1 every 3 cycles
    req_data[0 +: REQ_W]     = pack(21'h00A00, 8'h11, 1'b0, 1'b1);
    req_data[REQ_W +: REQ_W] = pack(21'h00B01, 8'h22, 1'b1, 1'b1);
    req_empty = '0;
    for (int k = 0; k < 12; k++) begin
      exp_rd = '0;
      if (k % 3 == 0) begin
        exp_rd[(k / 3) % 2] = 1'b1;
        if ((k / 3) % 2 == 0) wr_q.push_back('{21'h00A00, 8'h11, 1'b0});
        else                  wr_q.push_back('{21'h00B01, 8'h22, 1'b1});
      end
      smp(); check("alt_grant", 64'(req_rd), 64'(exp_rd));
      nxt();
    end
    req_empty = '1;
    smp(); check("alt_idle", 64'(req_rd), 64'd0);

    // ch0 read with response FIFO full at sample time
    nxt();
    req_data[0 +: REQ_W] = pack(21'h00077, 8'h00, 1'b0, 1'b0);
    req_empty[0] = 1'b0;
    smp(); check("f_grant", 64'(req_rd), 64'd1);
    nxt();
    nxt(); req_empty[0] = 1'b1;
    nxt();
    nxt(); rsp_full[0] = 1'b1; sd_dout = 16'h1234;
    nxt(); sd_dout = 16'h0F0F;
    smp(); check("f_no_wr", 64'(rsp_wr), 64'd0); check("f_err", 64'(err), 64'd1);
    nxt(); err_clr = 1'b1;
    smp(); check("f_err_hold", 64'(err), 64'd1);
    nxt(); err_clr = 1'b0; rsp_full = '0;
    smp(); check("f_err_clr", 64'(err), 64'd0);

    // ch1 read underflow with err_clr held in the same cycle: set wins, command still runs
    nxt();
    req_data[REQ_W +: REQ_W] = pack(21'h0ABCD, 8'h00, 1'b0, 1'b0);
    req_empty[1] = 1'b0;
    rsp_q.push_back('{1, 16'h5A5A});
    smp(); check("u_grant", 64'(req_rd), 64'd2);
    nxt(); req_empty[1] = 1'b1; err_clr = 1'b1;
    nxt(); err_clr = 1'b0;
    smp(); check("u_err", 64'(err), 64'd1); check("u_addr", 64'(sd_addr), 64'h0ABCD);
    nxt();
    nxt(); sd_dout = 16'h5A5A;
    nxt(); sd_dout = 16'h0F0F;
    smp(); check("u_rsp_wr", 64'(rsp_wr), 64'd2);

    // sdram_ready low blocks grants; raising it grants ch0
    nxt();
    sdram_ready = 1'b0;
    req_data[0 +: REQ_W]     = pack(21'h00C00, 8'h33, 1'b0, 1'b1);
    req_data[REQ_W +: REQ_W] = pack(21'h00D00, 8'h44, 1'b0, 1'b1);
    req_empty = '0;
    for (int k = 0; k < 4; k++) begin
      smp(); check("nr_idle", 64'(req_rd), 64'd0);
      nxt();
    end
    sdram_ready = 1'b1;
    wr_q.push_back('{21'h00C00, 8'h33, 1'b0});
    smp(); check("nr_grant", 64'(req_rd), 64'd1);
    nxt();
    // reset during CMD discards the in-flight write
    nxt(); rst = 1'b0;
    void'(wr_q.pop_back());
    smp(); check("mr_we", 64'(sd_we), 64'd0); check("mr_addr", 64'(sd_addr), 64'd0);
    check("mr_err", 64'(err), 64'd0); check("mr_req_rd", 64'(req_rd), 64'd0);
    nxt();
    nxt(); rst = 1'b1;
    wr_q.push_back('{21'h00C00, 8'h33, 1'b0});
    smp(); check("mr_restart", 64'(req_rd), 64'd1);
    nxt(); req_empty[1] = 1'b1;
    nxt(); req_empty[0] = 1'b1;
    smp(); check("mr_cmd_we", 64'(sd_we), 64'd1);
    nxt(); nxt(); nxt();
    smp();
    check("wr_q_left", 64'(wr_q.size()), 64'd0);
    check("rsp_q_left", 64'(rsp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
